// File: rtl/risc_pkg.sv
// Shared encodings for the fetch sequencer and the 16-register datapath:
// state codes, opcodes and instruction field positions.
package risc_pkg;

    typedef enum logic [2:0] {
        ST_RESET    = 3'b000,
        ST_DECODE   = 3'b001,
        ST_EXECUTE  = 3'b010,
        ST_MEM      = 3'b011,
        ST_STORE    = 3'b100,
        ST_FINISHED = 3'b101,
        ST_FETCH    = 3'b110,
        ST_ILLEGAL  = 3'b111
    } state_e;

    localparam logic [3:0] OP_LW  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [3:0] OP_BIZ = 4'b1011;
    localparam logic [3:0] OP_BNZ = 4'b1100;
    localparam logic [3:0] OP_JAL = 4'b1101;
    localparam logic [3:0] OP_JMP = 4'b1110;
    localparam logic [3:0] OP_JR  = 4'b1111;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 8;
    localparam int RS_MSB = 7;
    localparam int RS_LSB = 4;
    localparam int RT_MSB = 3;
    localparam int RT_LSB = 0;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/fetch_instr_reg.sv
// Instruction register with load enable and field split.
// Ports: clk, rst_n (sync, active-low), load, instr_in -> op/rd/rs/rt fields.
module fetch_instr_reg
    import risc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] instr_in,
    output logic [3:0]  op,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rt
);

    logic [15:0] ir;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (load) begin
            ir <= instr_in;
        end
    end

    assign op = ir[OP_MSB:OP_LSB];
    assign rd = ir[RD_MSB:RD_LSB];
    assign rs = ir[RS_MSB:RS_LSB];
    assign rt = ir[RT_MSB:RT_LSB];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches instructions, drives the datapath
// State sequence and counts retired instructions (saturating).
// Ports: clk, rst_n (sync, active-low), start, imem_* fetch interface,
// OpCode/Rd/Rs/Rt fields, State, PC, PC_Off, done, instr_count.
// Optional: FETCH_SINGLE_STEP_EN adds input step; each fetch after the
// first waits for step=1 before issuing the read.
module fetch_sequencer
    import risc_pkg::*;
#(
    parameter logic [5:0] LAST_PC    = 6'd63,
    parameter int         MEM_CYCLES = 1,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [5:0]       imem_addr,
    output logic             imem_rd_en,
    input  logic [15:0]      imem_rdata,
    input  logic             imem_valid,
    output logic [3:0]       OpCode,
    output logic [3:0]       Rd,
    output logic [3:0]       Rs,
    output logic [3:0]       Rt,
    output logic [2:0]       State,
    output logic [5:0]       PC,
    input  logic [5:0]       PC_Off,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             done,
    output logic [CNT_W-1:0] instr_count
);

    localparam int MCW = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;

    state_e           state;
    logic [5:0]       pc;
    logic [MCW-1:0]   mem_cnt;
    logic             load;

    // Only an outstanding read can be accepted; stray valids are ignored.
    assign load = (state == ST_FETCH) && imem_rd_en && imem_valid;

    fetch_instr_reg u_ir (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .instr_in (imem_rdata),
        .op       (OpCode),
        .rd       (Rd),
        .rs       (Rs),
        .rt       (Rt)
    );

    assign State     = state;
    assign PC        = pc;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RESET;
            pc          <= '0;
            mem_cnt     <= '0;
            imem_rd_en  <= 1'b0;
            done        <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                ST_RESET: begin
                    if (start) begin
                        state      <= ST_FETCH;
                        imem_rd_en <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (load) begin
                        state      <= ST_DECODE;
                        imem_rd_en <= 1'b0;
                    end
`ifdef FETCH_SINGLE_STEP_EN
                    else if (!imem_rd_en && step) begin
                        imem_rd_en <= 1'b1;
                    end
`endif
                end
                ST_DECODE: begin
                    state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (is_mem_op(OpCode)) begin
                        state   <= ST_MEM;
                        mem_cnt <= MCW'(MEM_CYCLES - 1);
                    end else begin
                        state <= ST_STORE;
                    end
                end
                ST_MEM: begin
                    if (mem_cnt == '0) begin
                        state <= ST_STORE;
                    end else begin
                        mem_cnt <= mem_cnt - 1'b1;
                    end
                end
                ST_STORE: begin
                    // 6-bit add: carry out is dropped, so the PC wraps.
                    pc <= pc + PC_Off;
                    if (instr_count != '1) begin
                        instr_count <= instr_count + 1'b1;
                    end
                    if (pc == LAST_PC) begin
                        state <= ST_FINISHED;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_FETCH;
`ifdef FETCH_SINGLE_STEP_EN
                        imem_rd_en <= 1'b0;
`else
                        imem_rd_en <= 1'b1;
`endif
                    end
                end
                ST_FINISHED: begin
                    state <= ST_FINISHED;
                end
                default: begin
                    state      <= ST_RESET;
                    imem_rd_en <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against a
// per-instruction reference model of the state sequence, PC and counter.
module tb_fetch_sequencer;
    import risc_pkg::*;

    localparam logic [5:0] LAST = 6'd40;
    localparam int         MEMC = 3;
    localparam int         CW   = 3;
    localparam int         CMAX = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [5:0]    imem_addr;
    logic          imem_rd_en;
    logic [15:0]   imem_rdata;
    logic          imem_valid;
    logic [3:0]    OpCode, Rd, Rs, Rt;
    logic [2:0]    State;
    logic [5:0]    PC;
    logic [5:0]    PC_Off;
    logic          done;
    logic [CW-1:0] instr_count;

    fetch_sequencer #(
        .LAST_PC    (LAST),
        .MEM_CYCLES (MEMC),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .OpCode      (OpCode),
        .Rd          (Rd),
        .Rs          (Rs),
        .Rt          (Rt),
        .State       (State),
        .PC          (PC),
        .PC_Off      (PC_Off),
        .done        (done),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [5:0]  m_pc;
    int          m_cnt;
    logic [15:0] m_ir;
    bit          m_fin;
    bit          m_rst;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, "_op"}, 32'(OpCode), 32'(m_ir[15:12]));
        chk({tag, "_rd"}, 32'(Rd), 32'(m_ir[11:8]));
        chk({tag, "_rs"}, 32'(Rs), 32'(m_ir[7:4]));
        chk({tag, "_rt"}, 32'(Rt), 32'(m_ir[3:0]));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(State), 32'h0);
        chk({tag, "_pc"}, 32'(PC), 32'h0);
        chk({tag, "_cnt"}, 32'(instr_count), 32'h0);
        chk({tag, "_rden"}, 32'(imem_rd_en), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk_fields(tag);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        start = 1'($urandom);
        imem_valid = 1'($urandom);
        imem_rdata = 16'($urandom);
        tick;
        tick;
        m_pc = '0;
        m_cnt = 0;
        m_ir = '0;
        m_fin = 1'b0;
        m_rst = 1'b0;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        start = 1'b0;
        imem_valid = 1'b0;
        tick;
        chk("idle_state", 32'(State), 32'h0);
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        chk("start_state", 32'(State), 32'h6);
        chk("start_rden", 32'(imem_rd_en), 32'h1);
        start = 1'($urandom);
    endtask

    task automatic run_instr(input logic [15:0] ins, input int lat,
                             input logic [5:0] off, input bit rst_mem);
        bit is_mem;
        is_mem = (ins[15:12] == 4'b1001) || (ins[15:12] == 4'b1010);
        PC_Off = 6'($urandom);
        for (int i = 0; i < lat; i++) begin
            imem_valid = 1'b0;
            imem_rdata = 16'($urandom);
            chk("stall_state", 32'(State), 32'h6);
            chk("stall_rden", 32'(imem_rd_en), 32'h1);
            chk("stall_addr", 32'(imem_addr), 32'(m_pc));
            chk_fields("stall");
            tick;
        end
        imem_valid = 1'b1;
        imem_rdata = ins;
        chk("fetch_state", 32'(State), 32'h6);
        chk("fetch_rden", 32'(imem_rd_en), 32'h1);
        chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
        tick;
        m_ir = ins;
        imem_valid = 1'($urandom);
        imem_rdata = 16'($urandom);
        chk("dec_state", 32'(State), 32'h1);
        chk("dec_rden", 32'(imem_rd_en), 32'h0);
        chk_fields("dec");
        tick;
        chk("exe_state", 32'(State), 32'h2);
        chk_fields("exe");
        PC_Off = off;
        tick;
        if (is_mem) begin
            for (int k = 0; k < MEMC; k++) begin
                chk("mem_state", 32'(State), 32'h3);
                chk_fields("mem");
                if (rst_mem && k == 1) begin
                    rst_n = 1'b0;
                    tick;
                    m_pc = '0;
                    m_cnt = 0;
                    m_ir = '0;
                    m_fin = 1'b0;
                    m_rst = 1'b1;
                    chk_reset_vals("memrst");
                    rst_n = 1'b1;
                    start = 1'b0;
                    imem_valid = 1'b0;
                    return;
                end
                tick;
            end
        end
        chk("st_state", 32'(State), 32'h4);
        chk("st_pc", 32'(PC), 32'(m_pc));
        chk_fields("st");
        tick;
        imem_valid = 1'b0;
        if (m_pc == LAST) m_fin = 1'b1;
        m_pc = m_pc + off;
        if (m_cnt < CMAX) m_cnt++;
        chk("post_pc", 32'(PC), 32'(m_pc));
        chk("post_cnt", 32'(instr_count), 32'(m_cnt));
        chk("post_done", 32'(done), 32'(m_fin));
        chk("post_state", 32'(State), m_fin ? 32'h5 : 32'h6);
        chk("post_rden", 32'(imem_rd_en), 32'(!m_fin));
    endtask

    task automatic post_finish;
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom);
            imem_valid = 1'($urandom);
            imem_rdata = 16'($urandom);
            tick;
            chk("fin_state", 32'(State), 32'h5);
            chk("fin_done", 32'(done), 32'h1);
            chk("fin_pc", 32'(PC), 32'(m_pc));
            chk("fin_cnt", 32'(instr_count), 32'(m_cnt));
            chk("fin_rden", 32'(imem_rd_en), 32'h0);
        end
    endtask

    initial begin
        logic [15:0] ins;
        int          lat;
        bit          rm;
        PC_Off = '0;
        imem_rdata = '0;
        do_reset;
        do_start;
        run_instr(16'h0123, 0, 6'd1, 1'b0);
        run_instr(16'h9450, 2, 6'd3, 1'b0);
        run_instr(16'h1abc, 4, 6'd1, 1'b0);
        run_instr(16'hA5C3, 0, 6'd1, 1'b1);
        tick;
        chk("after_memrst", 32'(State), 32'h0);
        do_start;
        run_instr(16'h2222, 1, 6'd62, 1'b0);
        run_instr(16'h3333, 0, 6'd5, 1'b0);
        run_instr(16'h4444, 0, 6'd37, 1'b0);
        run_instr(16'h9876, 1, 6'd1, 1'b0);
        post_finish;
        for (int e = 0; e < 8; e++) begin
            do_reset;
            do_start;
            for (int j = 0; j < 12 && !m_fin; j++) begin
                ins = 16'($urandom);
                if ($urandom_range(0, 2) == 0)
                    ins[15:12] = ($urandom_range(0, 1) == 0) ? OP_LW : OP_SW;
                lat = $urandom_range(0, 3);
                rm = ($urandom_range(0, 15) == 0);
                run_instr(ins, lat, 6'($urandom), rm);
                if (m_rst) begin
                    m_rst = 1'b0;
                    tick;
                    do_start;
                end
            end
            if (m_fin) post_finish;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream control stage for the 16-register datapath.
- Owns the program counter and fetches 16-bit instructions from instruction memory. Splits each instruction into OpCode/Rd/Rs/Rt and drives the 3-bit State sequence the datapath executes on.
- Consumes the datapath's PC_Off to advance the PC.
- Sequencer logic runs on posedge clk. Outputs are therefore stable at the datapath's negedge sampling point.

Parameters:
- LAST_PC, 6'd63, PC of the final program instruction; completing it enters FINISHED.
- MEM_CYCLES, 1, cycles spent in the MEM state for LW/SW (≥1).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  level; leaves RESET when high
- imem_addr  out  6  instruction memory address (= PC)
- imem_rd_en  out  1  instruction read request
- imem_rdata  in  16  instruction word
- imem_valid  in  1  imem_rdata valid this cycle
- OpCode  out  4  instr[15:12]
- Rd  out  4  instr[11:8]
- Rs  out  4  instr[7:4]
- Rt  out  4  instr[3:0]
- State  out  3  datapath state code
- PC  out  6  current program counter
- PC_Off  in  6  offset from the datapath; valid from EXECUTE negedge onward
- done  out  1  high in FINISHED
- instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- State encodings:
  - RESET=000, DECODE=001, EXECUTE=010, MEM=011, STORE=100, FINISHED=101, FETCH=110.
  - 111 is unreachable; if reached, next state is RESET.
- Reset (rst_n low at posedge), from any state including mid-fetch or mid-MEM:
  - State=RESET, PC=0, instruction register=0 (so OpCode/Rd/Rs/Rt=0).
  - imem_rd_en=0, done=0, instr_count=0.
- RESET: stays while start=0. With start=1, goes to FETCH next cycle.
- FETCH:
  - imem_rd_en=1, imem_addr=PC.
  - Holds until imem_valid=1. On that edge, latches imem_rdata into the instruction register and moves to DECODE.
  - imem_rd_en drops the cycle after acceptance.
  - Latency ≥1; a zero-wait memory asserting imem_valid in the first FETCH cycle is legal.
- DECODE: one cycle, then EXECUTE.
- EXECUTE: one cycle.
  - If OpCode is 1001 (LW) or 1010 (SW), go to MEM.
  - Otherwise go to STORE.
- MEM: MEM_CYCLES cycles, counted by a down-counter, then STORE.
- STORE: one cycle. At exit:
  - PC <= PC + PC_Off, modulo 64 (6-bit wrap, carry discarded). PC_Off=0 leaves PC unchanged.
  - instr_count increments, saturating at all-ones.
  - If the pre-update PC == LAST_PC, go to FINISHED. Otherwise go to FETCH.
- FINISHED: done=1; stays until reset. start is ignored.
- Field outputs are registered from the instruction register. They are constant from DECODE through STORE.
- imem_rdata is ignored when not in FETCH. imem_valid outside FETCH is ignored.

Optional Feature:
- Macro: FETCH_SINGLE_STEP_EN.
- With the macro defined:
  - Adds input step (1 bit).
  - After STORE, the sequencer holds in FETCH with imem_rd_en=0 until step=1 is seen at a posedge. The read is then issued.
  - Level-held step runs continuously.
- Without the macro: the port is absent, and STORE goes directly to an active FETCH.

Decomposition:
- Package risc_pkg holds:
  - state-encoding localparams;
  - opcode constants (OP_LW=4'b1001, OP_SW=4'b1010, OP_BIZ, OP_BNZ, OP_JAL, OP_JMP, OP_JR);
  - the instruction field bit positions.
- The same package is shared with the datapath.
- One natural sub-module: fetch_instr_reg. It is the instruction register with load enable, plus the field split.
- The FSM, PC and counter stay in fetch_sequencer.

Test Plan:
- Reset mid-MEM:
  - Stimulus: assert rst_n=0 at cycle 2 of MEM with MEM_CYCLES=3.
  - Required: next edge gives State=000, PC=0, instr_count=0, imem_rd_en=0.
- ALU instruction, zero-wait memory:
  - Stimulus: start=1, imem returns 16'h0123 with imem_valid in the first FETCH cycle, PC_Off=1.
  - Required: State sequence 110,001,010,100,110. OpCode=0, Rd=1, Rs=2, Rt=3. PC=1, instr_count=1.
- LW path:
  - Stimulus: instruction 16'h9450, MEM_CYCLES=2.
  - Required: EXECUTE→MEM held exactly 2 cycles→STORE.
- Fetch stall:
  - Stimulus: imem_valid delayed 4 cycles.
  - Required: State=110, imem_rd_en=1, imem_addr stable for all 4 cycles; latch occurs on the valid edge only.
- PC wrap:
  - Stimulus: PC=62, PC_Off=6'd5.
  - Required: PC becomes 3.
- Finish:
  - Stimulus: LAST_PC=2, run 3 instructions with PC_Off=1.
  - Required: done=1, State=101, instr_count=3. Further start/imem_valid activity causes no change.
